// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with a registered read port: dout updates one cycle after rd is accepted.
// A full FIFO rejects writes unless a read is accepted on the same edge. SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow ports.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Flush takes priority, so neither side is accepted during clr.
  assign rd_acc = rd & ~empty & ~clr;
  assign wr_acc = wr & (~full | rd_acc) & ~clr;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
        dout   <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param (DEPTH=16 and DEPTH=10 instances) against a queue model.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       clr, wr, rd;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       b_clr, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_almost_full, b_almost_empty;
  logic [3:0] b_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow, b_overflow, b_underflow;
`endif

  int errs;
  int checks;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ma_dout, mb_dout;
  bit         ma_ovf, ma_udf, mb_ovf, mb_udf;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(10)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .wr(b_wr), .rd(b_rd), .din(b_din), .dout(b_dout),
    .full(b_full), .empty(b_empty), .almost_full(b_almost_full), .almost_empty(b_almost_empty),
    .count(b_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(b_overflow), .underflow(b_underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int sa, sb;
    sa = qa.size();
    sb = qb.size();
    check({ph, ".a_count"}, 32'(count), 32'(sa));
    check({ph, ".a_empty"}, 32'(empty), 32'(sa == 0));
    check({ph, ".a_full"},  32'(full),  32'(sa == 16));
    check({ph, ".a_af"},    32'(almost_full),  32'(sa >= 14));
    check({ph, ".a_ae"},    32'(almost_empty), 32'(sa <= 2));
    check({ph, ".a_dout"},  32'(dout), 32'(ma_dout));
    check({ph, ".b_count"}, 32'(b_count), 32'(sb));
    check({ph, ".b_empty"}, 32'(b_empty), 32'(sb == 0));
    check({ph, ".b_full"},  32'(b_full),  32'(sb == 10));
    check({ph, ".b_af"},    32'(b_almost_full),  32'(sb >= 8));
    check({ph, ".b_ae"},    32'(b_almost_empty), 32'(sb <= 2));
    check({ph, ".b_dout"},  32'(b_dout), 32'(mb_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check({ph, ".a_ovf"}, 32'(overflow),    32'(ma_ovf));
    check({ph, ".a_udf"}, 32'(underflow),   32'(ma_udf));
    check({ph, ".b_ovf"}, 32'(b_overflow),  32'(mb_ovf));
    check({ph, ".b_udf"}, 32'(b_underflow), 32'(mb_udf));
`endif
  endtask

  // One clock: drive both FIFOs, advance the queue models by the accept rules, compare.
  task automatic step(input string ph,
                      input bit a_wr, input bit a_rd, input bit a_clr, input logic [7:0] a_din,
                      input bit x_wr, input bit x_rd, input bit x_clr, input logic [7:0] x_din);
    bit r_ok, w_ok;
    wr = a_wr; rd = a_rd; clr = a_clr; din = a_din;
    b_wr = x_wr; b_rd = x_rd; b_clr = x_clr; b_din = x_din;
    @(posedge clk);
    if (a_clr) begin
      qa.delete(); ma_ovf = 0; ma_udf = 0;
    end else begin
      r_ok = a_rd && qa.size() != 0;
      w_ok = a_wr && (qa.size() < 16 || r_ok);
      if (a_wr && !w_ok) ma_ovf = 1;
      if (a_rd && qa.size() == 0) ma_udf = 1;
      if (r_ok) ma_dout = qa.pop_front();
      if (w_ok) qa.push_back(a_din);
    end
    if (x_clr) begin
      qb.delete(); mb_ovf = 0; mb_udf = 0;
    end else begin
      r_ok = x_rd && qb.size() != 0;
      w_ok = x_wr && (qb.size() < 10 || r_ok);
      if (x_wr && !w_ok) mb_ovf = 1;
      if (x_rd && qb.size() == 0) mb_udf = 1;
      if (r_ok) mb_dout = qb.pop_front();
      if (w_ok) qb.push_back(x_din);
    end
    #1;
    check_all(ph);
  endtask

  task automatic a_step(input string ph, input bit w, input bit r, input bit c, input logic [7:0] d);
    step(ph, w, r, c, d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Reset asserted away from the edge with requests held active throughout.
  task automatic do_reset();
    wr = 1; rd = 1; din = 8'hA5; clr = 0;
    b_wr = 1; b_rd = 1; b_din = 8'hA5; b_clr = 0;
    rst = 1;
    qa.delete(); qb.delete();
    ma_dout = 0; mb_dout = 0;
    ma_ovf = 0; ma_udf = 0; mb_ovf = 0; mb_udf = 0;
    #1;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 0;
    wr = 0; rd = 0; b_wr = 0; b_rd = 0;
  endtask

  initial begin
    errs = 0; checks = 0;
    rst = 0; clr = 0; wr = 0; rd = 0; din = 0;
    b_clr = 0; b_wr = 0; b_rd = 0; b_din = 0;
    #2;
    do_reset();
    a_step("post_rst_idle", 0, 0, 0, 8'h00);
    a_step("post_rst_rd", 0, 1, 0, 8'h00);

    for (int i = 0; i < 16; i++) a_step("fill", 1, 0, 0, 8'(i));
    a_step("wr_full", 1, 0, 0, 8'hFF);
    for (int i = 0; i < 16; i++) a_step("drain", 0, 1, 0, 8'h00);

    a_step("empty_wr_rd", 1, 1, 0, 8'h3C);
    a_step("empty_wr_rd_next", 0, 1, 0, 8'h00);

    for (int i = 0; i < 16; i++) a_step("fill2", 1, 0, 0, 8'($urandom));
    a_step("full_wr_rd", 1, 1, 0, 8'h77);
    for (int i = 0; i < 16; i++) a_step("drain2", 0, 1, 0, 8'h00);

    for (int i = 0; i < 5; i++) a_step("prefill_clr", 1, 0, 0, 8'($urandom));
    a_step("clr", 1, 0, 1, 8'hEE);
    a_step("post_clr", 0, 0, 0, 8'h00);

    for (int i = 0; i < 6; i++) step("b_pre", 0, 0, 0, 8'h00, 1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 25; i++) begin
      step("b_pair_wr", 0, 0, 0, 8'h00, 1, 0, 0, 8'($urandom));
      step("b_pair_rd", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00);
    end
    for (int i = 0; i < 8; i++) step("b_drain", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      int unsigned wp;
      wp = ((i / 100) % 2 == 1) ? 70 : 30;
      if (i == 300) do_reset();
      step("rand",
           $urandom_range(99) < wp, $urandom_range(99) < (100 - wp), $urandom_range(49) == 0, 8'($urandom),
           $urandom_range(99) < wp, $urandom_range(99) < (100 - wp), $urandom_range(49) == 0, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
